// File: rtl/skeeball_pkg.sv
// Shared skeeball definitions: game state encodings and the advance controller FSM.
package skeeball_pkg;

  localparam logic [1:0] MENU    = 2'b00;
  localparam logic [1:0] PLAYING = 2'b01;
  localparam logic [1:0] FINISH  = 2'b10;
  localparam logic [1:0] SCORE   = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRE     = 2'd1,
    WAIT_ACK = 2'd2
  } ctrl_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/skeeball_debounce.sv
// Two-flop synchronizer plus level debouncer; emits a one-cycle pulse on an accepted rising level.
module skeeball_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_reg;
  logic       sync2_reg;
  logic       level_reg;
  logic       rise_reg;
  logic [7:0] cnt_reg;

  // cnt_reg counts consecutive samples that disagree with the accepted level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= din;
      sync2_reg <= sync1_reg;
      rise_reg  <= 1'b0;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_reg <= sync2_reg;
        rise_reg  <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 8'd1;
      end
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/skeeball_advance_ctrl.sv
// Skeeball advance controller: decides when to pulse trigger to step the game state register.
module skeeball_advance_ctrl
  import skeeball_pkg::*;
#(
  parameter int BALLS_PER_GAME  = 9,
  parameter int FINISH_TICKS    = 150,
  parameter int SCORE_TICKS     = 500,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic       start_btn,
  input  logic       ball_sensor,
  input  logic [1:0] state,
  output logic       trigger,
  output logic [3:0] balls_left
);

  localparam logic [3:0]  BALLS_INIT = 4'(BALLS_PER_GAME);
  localparam logic [15:0] FINISH_LIM = 16'(FINISH_TICKS);
  localparam logic [15:0] SCORE_LIM  = 16'(SCORE_TICKS);

  ctrl_state_t fsm_reg;
  logic [1:0]  st_q;
  logic [1:0]  state_prev_reg;
  logic [15:0] timer_reg;
  logic [3:0]  balls_reg;
  logic        trigger_reg;

  logic [1:0]  raw_in;
  logic [1:0]  evt;
  logic        press_evt;
  logic        ball_evt;
  logic        state_changed;
  logic        advance;

  // index 0: start button, index 1: ball sensor
  assign raw_in = {ball_sensor, start_btn};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_db
      skeeball_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (raw_in[gi]),
        .rise (evt[gi])
      );
    end
  endgenerate

  assign press_evt     = evt[0];
  assign ball_evt      = evt[1];
  assign state_changed = (state != state_prev_reg);

  // A freshly changed state is evaluated only once the timer and ball count reflect it
  always_comb begin
    advance = 1'b0;
    if (!state_changed) begin
      case (state)
        MENU:    advance = press_evt;
        PLAYING: advance = (balls_reg == 4'd0);
        FINISH:  advance = (timer_reg >= FINISH_LIM);
        SCORE:   advance = press_evt || (timer_reg >= SCORE_LIM);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_prev_reg <= MENU;
      timer_reg      <= '0;
      balls_reg      <= '0;
    end else begin
      state_prev_reg <= state;

      if (state_changed) begin
        timer_reg <= '0;
      end else if (tick_i && fsm_reg == IDLE) begin
        timer_reg <= sat_inc16(timer_reg);
      end

      // Load on entry to Playing takes priority over a coincident ball
      if (state == PLAYING && state_changed) begin
        balls_reg <= BALLS_INIT;
      end else if (ball_evt && state == PLAYING && fsm_reg == IDLE && balls_reg != 4'd0) begin
        balls_reg <= balls_reg - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_reg     <= IDLE;
      st_q        <= MENU;
      trigger_reg <= 1'b0;
    end else begin
      trigger_reg <= 1'b0;
      case (fsm_reg)
        IDLE: begin
          if (advance) begin
            fsm_reg     <= FIRE;
            st_q        <= state;
            trigger_reg <= 1'b1;
          end
        end
        FIRE: begin
          fsm_reg <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (state != st_q) fsm_reg <= IDLE;
        end
        default: begin
          fsm_reg <= IDLE;
        end
      endcase
    end
  end

  assign trigger    = trigger_reg;
  assign balls_left = balls_reg;

endmodule
